mod_updown_counter: RTL and testbench

//  - Parametrised modulo-N up/down counter; next generation of the team's free-running 3-bit counter.
//  - Adds count enable, direction, synchronous parallel load, wrap/saturate mode, terminal-count and overflow flags.
//  - Sits in the clock/timing utilities; drives LED/display counters and tick generators from one board clock.

---
 rtl/mod_updown_counter_if.sv | 24 ++
 rtl/mod_updown_counter.sv | 95 +++++++++
 tb/tb_mod_updown_counter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the controls; the counter is the slave.
interface mod_updown_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up_dn;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] counter_out;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up_dn, sat, load, load_val,
        input  counter_out, tc, ovf
    );

    modport slave (
        input  en, up_dn, sat, load, load_val,
        output counter_out, tc, ovf
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, saturate/wrap, tc and ovf flags.
// Define COUNTER_PRESCALE_EN to step once per PRESCALE enabled cycles.
module mod_updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 2**WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic                 clk,
    input  logic                 neg_reset,
    mod_updown_counter_if.slave  bus
);
    localparam logic [WIDTH:0]   MAX   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_N = MAX[WIDTH-1:0];

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH || PRESCALE < 1)
    begin : g_bad_param
        $error("mod_updown_counter: illegal parameter set");
    end

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_q;
    logic             ovf_nxt;
    logic [WIDTH:0]   count_w;
    logic [WIDTH:0]   load_w;
    logic             tick;
    logic             step;

    assign count_w = {1'b0, count};
    assign load_w  = {1'b0, bus.load_val};

`ifdef COUNTER_PRESCALE_EN
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    assign tick = (presc == PMAX);

    always_ff @(posedge clk) begin
        if (!neg_reset) begin
            presc <= '0;
        end else if (bus.load) begin
            presc <= '0;
        end else if (bus.en) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step = bus.en & tick;

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (bus.load) begin
            count_nxt = (load_w > MAX) ? MAX_N : bus.load_val;
        end else if (step) begin
            // Out-of-range state recovers toward the bound of travel
            if (count_w > MAX) begin
                count_nxt = bus.up_dn ? '0 : MAX_N;
            end else if (bus.up_dn) begin
                if (count_w == MAX) begin
                    count_nxt = bus.sat ? MAX_N : '0;
                    ovf_nxt   = ~bus.sat;
                end else begin
                    count_nxt = WIDTH'(count_w + (WIDTH+1)'(1));
                end
            end else begin
                if (count_w == '0) begin
                    count_nxt = bus.sat ? '0 : MAX_N;
                    ovf_nxt   = ~bus.sat;
                end else begin
                    count_nxt = WIDTH'(count_w - (WIDTH+1)'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!neg_reset) begin
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.counter_out = count;
    assign bus.ovf         = ovf_q;
    assign bus.tc          = bus.up_dn ? (count_w == MAX) : (count_w == '0);
endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter at MODULUS 6 and 8: directed table
// plus randomized traffic against an arithmetic reference model.
module tb_mod_updown_counter;
    localparam int W = 3;
`ifdef COUNTER_PRESCALE_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       up;
        logic       sat;
        logic       ld;
        logic [2:0] lv;
        logic [2:0] cnt;
        logic       tc;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic neg_reset;

    mod_updown_counter_if #(.WIDTH(W)) bus6();
    mod_updown_counter_if #(.WIDTH(W)) bus8();

    mod_updown_counter #(.WIDTH(W), .MODULUS(6), .PRESCALE(3)) dut6 (
        .clk(clk), .neg_reset(neg_reset), .bus(bus6)
    );
    mod_updown_counter #(.WIDTH(W), .MODULUS(8), .PRESCALE(3)) dut8 (
        .clk(clk), .neg_reset(neg_reset), .bus(bus8)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mods[2] = '{6, 8};
    int mc[2];
    int mo[2];
    int mph[2];

    logic       r_rst, r_en, r_up, r_sat, r_ld;
    logic [2:0] r_lv;
    vec_t       tbl[$];

    function automatic vec_t mk(logic r, logic e, logic u, logic s,
                                logic l, logic [2:0] lv,
                                logic [2:0] c, logic t, logic o);
        vec_t v;
        v.rst_n = r; v.en = e; v.up = u; v.sat = s; v.ld = l;
        v.lv = lv; v.cnt = c; v.tc = t; v.ovf = o;
        return v;
    endfunction

    task automatic drive(input logic rst_n, input logic en,
                         input logic up, input logic sat,
                         input logic ld, input logic [2:0] lv);
        neg_reset = rst_n;
        r_rst = rst_n; r_en = en; r_up = up;
        r_sat = sat; r_ld = ld; r_lv = lv;
        bus6.en = en; bus6.up_dn = up; bus6.sat = sat;
        bus6.load = ld; bus6.load_val = lv;
        bus8.en = en; bus8.up_dn = up; bus8.sat = sat;
        bus8.load = ld; bus8.load_val = lv;
    endtask

    // Reference: value range 0..MOD-1, phase counts enabled cycles
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int maxv;
            maxv = mods[k] - 1;
            mo[k] = 0;
            if (!r_rst) begin
                mc[k] = 0;
                mph[k] = 0;
            end else if (r_ld) begin
                mc[k] = (int'(r_lv) > maxv) ? maxv : int'(r_lv);
                mph[k] = 0;
            end else if (r_en) begin
                mph[k] = mph[k] + 1;
                if (mph[k] == P) begin
                    mph[k] = 0;
                    if (r_up) begin
                        if (mc[k] < maxv) mc[k] = mc[k] + 1;
                        else if (!r_sat) begin mc[k] = 0; mo[k] = 1; end
                    end else begin
                        if (mc[k] > 0) mc[k] = mc[k] - 1;
                        else if (!r_sat) begin mc[k] = maxv; mo[k] = 1; end
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic [2:0] c;
            logic       t, o, et;
            c = (k == 0) ? bus6.counter_out : bus8.counter_out;
            t = (k == 0) ? bus6.tc : bus8.tc;
            o = (k == 0) ? bus6.ovf : bus8.ovf;
            et = r_up ? (mc[k] == mods[k] - 1) : (mc[k] == 0);
            tests++;
            if (c !== 3'(mc[k]) || t !== et || o !== 1'(mo[k])) begin
                fails++;
                $display("FAIL model_mod%0d t=%0t got cnt=%0d tc=%b ovf=%b expected cnt=%0d tc=%b ovf=%0d",
                         mods[k], $time, c, t, o, mc[k], et, mo[k]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mo[k] = 0; mph[k] = 0;
        end
        @(posedge clk);
        #1;

        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0));
`ifdef COUNTER_PRESCALE_EN
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1,1,1,0,0,0, 3'((i + 1) / 3),0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 3,0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 3,0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 3,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 3,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 4,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 4,0,0));
        tbl.push_back(mk(1,1,1,0,1,1, 1,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 1,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 1,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 2,0,0));
        tbl.push_back(mk(1,1,1,0,1,7, 5,1,0));
        tbl.push_back(mk(1,1,1,0,0,0, 5,1,0));
        tbl.push_back(mk(1,1,1,0,0,0, 5,1,0));
        tbl.push_back(mk(1,1,1,0,0,0, 0,0,1));
        tbl.push_back(mk(0,1,1,0,1,3, 0,0,0));
`else
        tbl.push_back(mk(1,1,1,0,0,0, 1,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 2,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 3,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 4,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 5,1,0));
        tbl.push_back(mk(1,1,1,0,0,0, 0,0,1));
        tbl.push_back(mk(1,1,1,0,0,0, 1,0,0));
        tbl.push_back(mk(1,0,0,0,1,2, 2,0,0));
        tbl.push_back(mk(1,1,0,1,0,0, 1,0,0));
        tbl.push_back(mk(1,1,0,1,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,1,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,1,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0, 5,0,1));
        tbl.push_back(mk(1,0,0,0,0,0, 5,0,0));
        tbl.push_back(mk(1,1,1,0,1,7, 5,1,0));
        tbl.push_back(mk(0,1,1,0,1,3, 0,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 1,0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 1,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 2,0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 2,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 3,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 3,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 2,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 2,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0, 5,0,1));
`endif

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].en, tbl[i].up,
                  tbl[i].sat, tbl[i].ld, tbl[i].lv);
            cycle();
            tests++;
            if (bus6.counter_out !== tbl[i].cnt || bus6.tc !== tbl[i].tc ||
                bus6.ovf !== tbl[i].ovf) begin
                fails++;
                $display("FAIL vec%0d got cnt=%0d tc=%b ovf=%b expected cnt=%0d tc=%b ovf=%b",
                         i, bus6.counter_out, bus6.tc, bus6.ovf,
                         tbl[i].cnt, tbl[i].tc, tbl[i].ovf);
            end
        end

        begin
            logic up;
            up = 1'b1;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(7) == 0) up = ~up;
                drive($urandom_range(31) != 0,
                      $urandom_range(3) != 0,
                      up,
                      $urandom_range(3) == 0,
                      $urandom_range(9) == 0,
                      3'($urandom_range(7)));
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
